// File: rtl/pow_nonce_search.sv
// rtl/pow_nonce_search.sv - proof-of-work nonce search controller
//
// Builds candidate messages {header, nonce} for the downstream Pearson hasher.
// Each returned hash is compared against a difficulty target. Nonces are
// walked upward until a hit, until max_nonce is exhausted, or until abort.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, abort    begin a search (IDLE/FOUND/EXHAUSTED only) / cancel to IDLE
//   header, target, max_nonce   search parameters, latched on accepted start
//   msg_out, msg_valid          candidate message and its one-cycle strobe
//   hash_in, hash_valid         hasher response, accepted only in WAIT
//   busy, found, exhausted      status (ISSUE/WAIT/CHECK, FOUND, EXHAUSTED)
//   nonce_out, hash_out         winning nonce and its hash
//   attempts                    CHECK count since start (POW_ATTEMPT_CNT_EN only)
//
// Optional feature macro: POW_ATTEMPT_CNT_EN
module pow_nonce_search #(
  parameter int HDR_W   = 8,
  parameter int NONCE_W = 24,
  parameter int HASH_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [HDR_W-1:0]   header,
  input  logic [HASH_W-1:0]  target,
  input  logic [NONCE_W-1:0] max_nonce,
  output logic [31:0]        msg_out,
  output logic               msg_valid,
  input  logic [HASH_W-1:0]  hash_in,
  input  logic               hash_valid,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic [NONCE_W-1:0] nonce_out,
  output logic [HASH_W-1:0]  hash_out
`ifdef POW_ATTEMPT_CNT_EN
  ,
  output logic [31:0]        attempts
`endif
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_FOUND, S_EXHAUSTED
  } state_t;

  state_t             state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] max_q, max_d;
  logic [NONCE_W-1:0] nonce_out_q, nonce_out_d;
  logic [HDR_W-1:0]   hdr_q, hdr_d;
  logic [HASH_W-1:0]  tgt_q, tgt_d;
  logic [HASH_W-1:0]  hash_cap_q, hash_cap_d;
  logic [HASH_W-1:0]  hash_out_q, hash_out_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [31:0]        msg_q, msg_d;
  logic               msg_valid_q, msg_valid_d;
  logic               busy_q, busy_d;
  logic               found_q, found_d;
  logic               exh_q, exh_d;
`ifdef POW_ATTEMPT_CNT_EN
  logic [31:0]        attempts_q, attempts_d;
`endif

  always_comb begin
    state_d     = state_q;
    nonce_d     = nonce_q;
    max_d       = max_q;
    nonce_out_d = nonce_out_q;
    hdr_d       = hdr_q;
    tgt_d       = tgt_q;
    hash_cap_d  = hash_cap_q;
    hash_out_d  = hash_out_q;
    tmo_d       = tmo_q;
    msg_d       = msg_q;
`ifdef POW_ATTEMPT_CNT_EN
    attempts_d  = attempts_q;
`endif

    if (abort) begin
      // Keeps the latched search parameters and the attempt count.
      state_d     = S_IDLE;
      nonce_d     = '0;
      tmo_d       = '0;
      hash_cap_d  = '0;
      nonce_out_d = '0;
      hash_out_d  = '0;
      msg_d       = '0;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            hdr_d       = header;
            tgt_d       = target;
            max_d       = max_nonce;
            nonce_d     = '0;
            nonce_out_d = '0;
            hash_out_d  = '0;
`ifdef POW_ATTEMPT_CNT_EN
            attempts_d  = '0;
`endif
            state_d     = S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // A response on the final WAIT cycle still wins over the retry.
          if (hash_valid) begin
            hash_cap_d = hash_in;
            state_d    = S_CHECK;
          end else if (tmo_q == TMO_LAST) begin
            state_d = S_ISSUE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_CHECK: begin
`ifdef POW_ATTEMPT_CNT_EN
          if (attempts_q != '1) attempts_d = attempts_q + 32'd1;
`endif
          if (hash_cap_q < tgt_q) begin
            nonce_out_d = nonce_q;
            hash_out_d  = hash_cap_q;
            state_d     = S_FOUND;
          end else if (nonce_q == max_q) begin
            // Stopping here, before the increment, is what keeps the nonce from wrapping.
            state_d = S_EXHAUSTED;
          end else begin
            nonce_d = nonce_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    msg_valid_d = (state_d == S_ISSUE);
    if (state_d == S_ISSUE) msg_d = {hdr_d, nonce_d};
    busy_d  = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CHECK);
    found_d = (state_d == S_FOUND);
    exh_d   = (state_d == S_EXHAUSTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      nonce_q     <= '0;
      max_q       <= '0;
      nonce_out_q <= '0;
      hdr_q       <= '0;
      tgt_q       <= '0;
      hash_cap_q  <= '0;
      hash_out_q  <= '0;
      tmo_q       <= '0;
      msg_q       <= '0;
      msg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      found_q     <= 1'b0;
      exh_q       <= 1'b0;
`ifdef POW_ATTEMPT_CNT_EN
      attempts_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      nonce_q     <= nonce_d;
      max_q       <= max_d;
      nonce_out_q <= nonce_out_d;
      hdr_q       <= hdr_d;
      tgt_q       <= tgt_d;
      hash_cap_q  <= hash_cap_d;
      hash_out_q  <= hash_out_d;
      tmo_q       <= tmo_d;
      msg_q       <= msg_d;
      msg_valid_q <= msg_valid_d;
      busy_q      <= busy_d;
      found_q     <= found_d;
      exh_q       <= exh_d;
`ifdef POW_ATTEMPT_CNT_EN
      attempts_q  <= attempts_d;
`endif
    end
  end

  assign msg_out   = msg_q;
  assign msg_valid = msg_valid_q;
  assign busy      = busy_q;
  assign found     = found_q;
  assign exhausted = exh_q;
  assign nonce_out = nonce_out_q;
  assign hash_out  = hash_out_q;
`ifdef POW_ATTEMPT_CNT_EN
  assign attempts  = attempts_q;
`endif

endmodule

// File: tb/tb_pow_nonce_search.sv
// tb/tb_pow_nonce_search.sv - scoreboard bench for pow_nonce_search
module tb_pow_nonce_search;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [7:0]  header, target;
  logic [23:0] max_nonce;
  logic [31:0] msg_out;
  logic        msg_valid;
  logic [7:0]  hash_in;
  logic        hash_valid;
  logic        busy, found, exhausted;
  logic [23:0] nonce_out;
  logic [7:0]  hash_out;
`ifdef POW_ATTEMPT_CNT_EN
  logic [31:0] attempts;
`endif

  // Hasher responses come from the hasher process; stale responses from the main flow.
  logic        hv_model = 1'b0, hv_stale = 1'b0;
  logic [7:0]  hin_model = 8'h00, hin_stale = 8'h00;
  assign hash_valid = hv_model | hv_stale;
  assign hash_in    = hv_stale ? hin_stale : hin_model;

  pow_nonce_search #(.HDR_W(8), .NONCE_W(24), .HASH_W(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .header(header), .target(target), .max_nonce(max_nonce),
    .msg_out(msg_out), .msg_valid(msg_valid),
    .hash_in(hash_in), .hash_valid(hash_valid),
    .busy(busy), .found(found), .exhausted(exhausted),
    .nonce_out(nonce_out), .hash_out(hash_out)
`ifdef POW_ATTEMPT_CNT_EN
    , .attempts(attempts)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Hasher model: hash of a candidate is looked up by the low nonce bits.
  logic [7:0] htab [16];
  bit         hasher_on   = 1'b1;
  int         fixed_delay = 1;

  initial begin
    logic [31:0] m;
    int          k;
    forever begin
      @(negedge clk);
      if (msg_valid && hasher_on) begin
        m = msg_out;
        k = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, TMO));
        repeat (k) @(negedge clk);
        hin_model = htab[m[3:0]];
        hv_model  = 1'b1;
        @(negedge clk);
        hv_model  = 1'b0;
        hin_model = 8'h00;
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic        f;
    logic [23:0] n;
    logic [7:0]  h;
    int          a;
  } res_t;

  logic [31:0] exp_msg [$];
  res_t        exp_res [$];

  // Reference: first nonce whose hash is strictly below target wins; else all tried.
  task automatic model_push(input logic [7:0] h, input logic [7:0] t, input int m);
    res_t r;
    bit   hit = 1'b0;
    for (int n = 0; n <= m && !hit; n++) begin
      exp_msg.push_back({h, 24'(n)});
      if (htab[n] < t) begin
        r.f = 1'b1; r.n = 24'(n); r.h = htab[n]; r.a = n + 1;
        hit = 1'b1;
      end
    end
    if (!hit) begin
      r.f = 1'b0; r.n = 24'h0; r.h = 8'h0; r.a = m + 1;
    end
    exp_res.push_back(r);
  endtask

  // Monitor
  initial begin
    logic  prev_done = 1'b0;
    logic  done;
    res_t  r;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (msg_valid) begin
        if (exp_msg.size() == 0) fail_now("unexpected msg_valid");
        else begin
          e = exp_msg.pop_front();
          check("msg_out", 64'(msg_out), 64'(e));
        end
      end
      if (found && exhausted) fail_now("found and exhausted both high");
      done = found | exhausted;
      if (done && !prev_done) begin
        if (exp_res.size() == 0) fail_now("unexpected completion");
        else begin
          r = exp_res.pop_front();
          check("found", 64'(found), 64'(r.f));
          check("exhausted", 64'(exhausted), 64'(!r.f));
          check("busy_at_done", 64'(busy), 64'd0);
          check("nonce_out", 64'(nonce_out), 64'(r.n));
          check("hash_out", 64'(hash_out), 64'(r.h));
`ifdef POW_ATTEMPT_CNT_EN
          check("attempts", 64'(attempts), 64'(r.a));
`endif
        end
      end
      prev_done = done;
    end
  end

  int t_start;

  task automatic do_start(input logic [7:0] h, input logic [7:0] t, input logic [23:0] m);
    @(negedge clk);
    header = h; target = t; max_nonce = m; start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int t);
    bit ok = 1'b0;
    t = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (found || exhausted) begin
        ok = 1'b1;
        t = cyc;
      end
    end
    if (!ok) fail_now("search did not complete");
  endtask

  task automatic wait_pulse(output int t);
    bit ok = 1'b0;
    t = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (msg_valid) begin
        ok = 1'b1;
        t = cyc;
      end
    end
    if (!ok) fail_now("msg_valid pulse missing");
  endtask

  task automatic finish_check(input string name);
    @(negedge clk);
    check({name, "_msgs_left"}, 64'(exp_msg.size()), 64'd0);
    check({name, "_results_left"}, 64'(exp_res.size()), 64'd0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_found"}, 64'(found), 64'd0);
    check({name, "_exhausted"}, 64'(exhausted), 64'd0);
    check({name, "_msg_out"}, 64'(msg_out), 64'd0);
    check({name, "_msg_valid"}, 64'(msg_valid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tf, p1, p2, p3, p4;
    logic [7:0] h, t;
    int m;

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    header = 8'h00; target = 8'h00; max_nonce = 24'h0;
    for (int i = 0; i < 16; i++) htab[i] = 8'hFF;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_nonce_out", 64'(nonce_out), 64'd0);
    check("reset_hash_out", 64'(hash_out), 64'd0);
`ifdef POW_ATTEMPT_CNT_EN
    check("reset_attempts", 64'(attempts), 64'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Hit on the third candidate, one-cycle hasher latency
    htab[0] = 8'h80; htab[1] = 8'h40; htab[2] = 8'h0F;
    fixed_delay = 1;
    model_push(8'hA5, 8'h10, 5);
    do_start(8'hA5, 8'h10, 24'd5);
    wait_done(tf);
    check("start_to_found_cycles", 64'(tf - t_start), 64'd10);
    finish_check("hit3");

    // Unreachable target
    for (int i = 0; i < 16; i++) htab[i] = $urandom;
    model_push(8'h5A, 8'h00, 3);
    do_start(8'h5A, 8'h00, 24'd3);
    wait_done(tf);
    finish_check("target0");

    // Equality is not a hit
    htab[0] = 8'h05;
    model_push(8'h11, 8'h05, 0);
    do_start(8'h11, 8'h05, 24'd0);
    wait_done(tf);
    finish_check("equal");

    // Timeout retry: three unanswered issues, the fourth gets a response
    for (int i = 0; i < 16; i++) htab[i] = $urandom;
    hasher_on = 1'b0;
    model_push(8'hC3, 8'h80, 4);
    for (int i = 0; i < 3; i++) exp_msg.push_front(32'hC300_0000);
    do_start(8'hC3, 8'h80, 24'd4);
    p1 = cyc;
    check("retry_first_issue", 64'(msg_valid), 64'd1);
    wait_pulse(p2);
    check("retry_period_1", 64'(p2 - p1), 64'(TMO + 1));
    wait_pulse(p3);
    check("retry_period_2", 64'(p3 - p2), 64'(TMO + 1));
    @(posedge clk);
    hasher_on = 1'b1;
    fixed_delay = 2;
    wait_pulse(p4);
    check("retry_period_3", 64'(p4 - p3), 64'(TMO + 1));
    wait_done(tf);
    finish_check("retry");

    // Abort then reset while waiting on nonce 2
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) htab[i] = $urandom;
      fixed_delay = 3;
      for (int n = 0; n < 3; n++) exp_msg.push_back({8'h99, 24'(n)});
      do_start(8'h99, 8'h00, 24'd6);
      wait_pulse(p2);
      wait_pulse(p3);
      @(negedge clk);
      if (pass == 0) abort = 1'b1; else reset = 1'b1;
      @(negedge clk);
      abort = 1'b0; reset = 1'b0;
      hin_stale = 8'h00; hv_stale = 1'b1;
      @(negedge clk);
      hv_stale = 1'b0;
      repeat (8) @(negedge clk);
      check_idle(pass == 0 ? "abort" : "midreset");
`ifdef POW_ATTEMPT_CNT_EN
      check("attempts_after_cancel", 64'(attempts), (pass == 0) ? 64'd2 : 64'd0);
`endif
      finish_check(pass == 0 ? "abort" : "midreset");
    end

    // Start while busy is ignored; start in FOUND restarts with the new header
    for (int i = 0; i < 16; i++) htab[i] = 8'hF0;
    htab[0] = 8'h90; htab[1] = 8'h20;
    fixed_delay = 4;
    model_push(8'h77, 8'h30, 3);
    do_start(8'h77, 8'h30, 24'd3);
    repeat (2) @(negedge clk);
    header = 8'h11; target = 8'h00; max_nonce = 24'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tf);
    finish_check("busy_start");
    htab[0] = 8'h01;
    model_push(8'h3C, 8'h30, 2);
    do_start(8'h3C, 8'h30, 24'd2);
    check("restart_clears_found", 64'(found), 64'd0);
    wait_done(tf);
    finish_check("restart");

    // Randomized searches against the reference
    for (int it = 0; it < 25; it++) begin
      h = 8'($urandom);
      t = (it % 5 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      m = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) htab[i] = 8'($urandom);
      fixed_delay = 0;
      model_push(h, t, m);
      do_start(h, t, 24'(m));
      wait_done(tf);
      finish_check("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pow_nonce_search.md
Name: pow_nonce_search

Overview:
- Proof-of-work search controller that sits directly upstream of the 32-bit Pearson hash stage.
- Builds each candidate message as {header, nonce} and issues it to the hasher with a valid pulse.
- Takes the 8-bit hash back, compares it against a difficulty target, and walks nonces until a hit, exhaustion or abort.
- Reports the winning nonce and its hash to the miner top level.

Parameters:
- HDR_W, 8, header field width; upper bits of the message.
- NONCE_W, 24, nonce field width; HDR_W + NONCE_W must equal 32.
- HASH_W, 8, hash and target width.
- TIMEOUT, 64, WAIT cycles without hash_valid before the same candidate is reissued; minimum 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  begin a search; honoured only in IDLE, FOUND or EXHAUSTED.
- abort  in  1  cancel the search, return to IDLE.
- header  in  HDR_W  block header slice; latched on accepted start.
- target  in  HASH_W  difficulty; latched on accepted start.
- max_nonce  in  NONCE_W  last nonce to try; latched on accepted start.
- msg_out  out  32  candidate message {header_q, nonce}.
- msg_valid  out  1  one-cycle pulse; msg_out is valid.
- hash_in  in  HASH_W  hash result from the hasher.
- hash_valid  in  1  hash_in is valid this cycle.
- busy  out  1  high in ISSUE, WAIT and CHECK.
- found  out  1  high while in FOUND.
- exhausted  out  1  high while in EXHAUSTED.
- nonce_out  out  NONCE_W  winning nonce.
- hash_out  out  HASH_W  winning hash.

Behaviour:
- Reset and abort values:
  - reset: state IDLE; every output 0; internal nonce, latched header/target/max_nonce and timeout counter all 0.
  - abort has the same effect, except it does not clear the latched header/target/max_nonce.
  - reset has priority over abort; abort has priority over start and hash_valid.
- States: IDLE, ISSUE, WAIT, CHECK, FOUND, EXHAUSTED.
- IDLE/FOUND/EXHAUSTED + start:
  - latch header, target and max_nonce; nonce := 0; clear found, exhausted, nonce_out and hash_out; go to ISSUE.
  - start in any other state is ignored.
- ISSUE:
  - msg_valid = 1 for exactly this cycle; msg_out = {header_q, nonce}.
  - timeout counter := 0; go to WAIT.
- msg_out holds its value from ISSUE until the next ISSUE. It is 0 only after reset or abort.
- WAIT:
  - On hash_valid: capture hash_in and go to CHECK.
  - Else increment the timeout counter. When it reaches TIMEOUT-1, go to ISSUE with the same nonce (retry).
- hash_valid outside WAIT is ignored. That includes a late response after a retry, abort or reset.
- CHECK:
  - hash < target (unsigned, strict): go to FOUND; nonce_out := nonce; hash_out := captured hash.
  - else if nonce == max_nonce: go to EXHAUSTED.
  - else nonce := nonce + 1; go to ISSUE.
- The nonce never wraps: with max_nonce = all-ones, the search ends in EXHAUSTED at all-ones.
- target = 0 can never hit, so the search always ends EXHAUSTED after max_nonce+1 candidates.
- FOUND and EXHAUSTED hold all outputs until start, abort or reset.
- Per-candidate latency is 3 cycles minimum (ISSUE, WAIT with hash_valid on its first cycle, CHECK).
- found and exhausted are never high together. busy is low whenever either is high.

Optional Feature:
- Macro POW_ATTEMPT_CNT_EN.
- Defined:
  - Adds output attempts [31:0], which counts CHECK cycles since the last accepted start.
  - Saturates at 0xFFFFFFFF; cleared by reset and by accepted start, not by abort.
  - Retries are not counted.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Hit on third candidate:
  - Stimulus: header=0xA5, target=0x10, max_nonce=5; model returns 0x80, 0x40, 0x0F one cycle after each msg_valid.
  - Response: msg_out = 0xA5000000, 0xA5000001, 0xA5000002; found=1, nonce_out=0x000002, hash_out=0x0F; start-to-found takes 10 cycles; attempts=3 with the macro.
- Unreachable target:
  - Stimulus: target=0x00, max_nonce=3.
  - Response: exactly 4 msg_valid pulses; exhausted=1, found=0, busy=0.
- Equality is not a hit:
  - Stimulus: max_nonce=0, target=0x05, hash=0x05.
  - Response: exhausted=1 after a single candidate.
- Timeout retry:
  - Stimulus: TIMEOUT=4; model withholds hash_valid.
  - Response: msg_valid re-pulses every 5 cycles with an unchanged msg_out; a hash_valid then arriving in WAIT proceeds to CHECK normally.
- Abort and reset mid-search:
  - Stimulus: abort asserted in WAIT at nonce=2, then a stale hash_valid=1 with hash=0x00; repeat using reset.
  - Response: IDLE, busy=0, found=0, msg_out=0; the stale hash is ignored.
- Start handling:
  - Stimulus: start pulsed while busy; then start pulsed in FOUND with new header 0x3C.
  - Response: the start while busy has no effect; the start in FOUND clears found and the next msg_out is 0x3C000000.
